// File: rtl/cnn_stream_pkg.sv
// Shared constants and read-FSM state type for the CNN input streamer.
package cnn_stream_pkg;

    localparam int unsigned OUT_ROWS  = 48;
    localparam int unsigned OUT_COLS  = 48;
    localparam int unsigned FRAME_PIX = OUT_ROWS * OUT_COLS;
    localparam int unsigned PIX_CNT_W = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_START,
        RD_STREAM,
        RD_WAIT_DONE
    } rd_state_t;

endpackage

// File: rtl/cnn_pix_bram.sv
// Two-bank frame store: simple dual-port RAM addressed by {bank, pixel index},
// one-cycle registered read, no reset on contents.
module cnn_pix_bram
    import cnn_stream_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic                 i_wr_bank,
    input  logic [PIX_CNT_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    input  logic                 i_rd_bank,
    input  logic [PIX_CNT_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0]     o_rd_data
);

    logic [PIX_W-1:0] r_mem [2][FRAME_PIX];
    logic [PIX_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cnn_input_streamer.sv
// Ping-pong frame buffer between the cropnorm pixel stream and the HLS CNN input:
// writes whole 48x48 frames, then starts the CNN (ap_ctrl_hs) and streams each frame out.
module cnn_input_streamer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned AXIS_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PIX_W-1:0]  s_pix_tdata,
    input  logic              s_pix_tvalid,
    input  logic              s_pix_tlast,
    output logic              s_pix_tready,
    output logic [AXIS_W-1:0] m_cnn_tdata,
    output logic              m_cnn_tvalid,
    input  logic              m_cnn_tready,
    output logic              cnn_ap_start,
    input  logic              cnn_ap_ready,
    input  logic              cnn_ap_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_len
);

    localparam logic [PIX_CNT_W-1:0] LAST_IDX = PIX_CNT_W'(FRAME_PIX - 1);

    // Write side state
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic [PIX_CNT_W-1:0] r_wr_cnt;
    logic                 r_drop;
    logic                 r_pix_tready;
    logic                 r_err_len;

    // Read side state
    rd_state_t            r_state;
    logic                 r_rd_bank;
    logic [PIX_CNT_W-1:0] r_rd_cnt;
    logic                 r_issue_done;
    logic [PIX_CNT_W-1:0] r_tx_cnt;
    logic                 r_pend;
    logic                 r_m_valid;
    logic [PIX_W-1:0]     r_m_data;
    logic                 r_sk_valid;
    logic [PIX_W-1:0]     r_sk_data;
    logic                 r_ap_start;
    logic [CNT_W-1:0]     r_frame_cnt;

    logic                 w_wr_fire;
    logic                 w_wr_en;
    logic [1:0]           w_full_n;
    logic                 w_wr_bank_n;
    logic [PIX_CNT_W-1:0] w_wr_cnt_n;
    logic                 w_drop_n;
    logic                 w_err_n;
    logic                 w_rd_free;
    logic                 w_pop;
    logic [1:0]           w_occ;
    logic                 w_room;
    logic                 w_rd_en;
    logic [PIX_W-1:0]     w_rd_data;

    assign w_wr_fire = s_pix_tvalid & r_pix_tready;
    assign w_wr_en   = w_wr_fire & ~r_drop;
    assign w_rd_free = (r_state == RD_WAIT_DONE) & cnn_ap_done;

    // Frame length policing and bank hand-off; a long frame commits its first FRAME_PIX pixels
    always_comb begin
        w_full_n    = r_full;
        w_wr_bank_n = r_wr_bank;
        w_wr_cnt_n  = r_wr_cnt;
        w_drop_n    = r_drop;
        w_err_n     = 1'b0;
        if (w_wr_fire) begin
            if (r_drop) begin
                if (s_pix_tlast) begin
                    w_drop_n = 1'b0;
                end
            end else if (r_wr_cnt == LAST_IDX) begin
                w_full_n[r_wr_bank] = 1'b1;
                w_wr_bank_n         = ~r_wr_bank;
                w_wr_cnt_n          = '0;
                if (!s_pix_tlast) begin
                    w_err_n  = 1'b1;
                    w_drop_n = 1'b1;
                end
            end else if (s_pix_tlast) begin
                w_err_n    = 1'b1;
                w_wr_cnt_n = '0;
            end else begin
                w_wr_cnt_n = r_wr_cnt + PIX_CNT_W'(1);
            end
        end
        if (w_rd_free) begin
            w_full_n[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_wr_cnt     <= '0;
            r_drop       <= 1'b0;
            r_pix_tready <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            r_full       <= w_full_n;
            r_wr_bank    <= w_wr_bank_n;
            r_wr_cnt     <= w_wr_cnt_n;
            r_drop       <= w_drop_n;
            r_pix_tready <= w_drop_n | ~w_full_n[w_wr_bank_n];
            r_err_len    <= w_err_n;
        end
    end

    cnn_pix_bram #(
        .PIX_W(PIX_W)
    ) u_bram (
        .clk       (ap_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (s_pix_tdata),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    // Credit check: output + skid + in-flight read never exceed the two skid slots
    assign w_pop   = r_m_valid & m_cnn_tready;
    assign w_occ   = {1'b0, r_m_valid} + {1'b0, r_sk_valid} + {1'b0, r_pend};
    assign w_room  = (w_occ < 2'd2) | w_pop;
    assign w_rd_en = (r_state == RD_STREAM) & ~r_issue_done & w_room;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= RD_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_cnt     <= '0;
            r_issue_done <= 1'b0;
            r_tx_cnt     <= '0;
            r_pend       <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_sk_valid   <= 1'b0;
            r_sk_data    <= '0;
            r_ap_start   <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_pend <= w_rd_en;
            if (w_rd_en) begin
                if (r_rd_cnt == LAST_IDX) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt + PIX_CNT_W'(1);
                end
            end

            // Output register refills from skid first, then from the RAM read
            if (!r_m_valid || w_pop) begin
                if (r_sk_valid) begin
                    r_m_valid  <= 1'b1;
                    r_m_data   <= r_sk_data;
                    r_sk_valid <= r_pend;
                    r_sk_data  <= w_rd_data;
                end else begin
                    r_m_valid <= r_pend;
                    if (r_pend) begin
                        r_m_data <= w_rd_data;
                    end
                end
            end else if (r_pend) begin
                r_sk_valid <= 1'b1;
                r_sk_data  <= w_rd_data;
            end

            if (r_ap_start && cnn_ap_ready) begin
                r_ap_start <= 1'b0;
            end

            case (r_state)
                RD_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state      <= RD_START;
                        r_ap_start   <= 1'b1;
                        r_rd_cnt     <= '0;
                        r_issue_done <= 1'b0;
                        r_tx_cnt     <= '0;
                    end
                end
                RD_START: begin
                    r_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (w_pop) begin
                        if (r_tx_cnt == LAST_IDX) begin
                            r_state <= RD_WAIT_DONE;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + PIX_CNT_W'(1);
                        end
                    end
                end
                RD_WAIT_DONE: begin
                    if (cnn_ap_done) begin
                        r_rd_bank   <= ~r_rd_bank;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_state     <= RD_IDLE;
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    assign s_pix_tready = r_pix_tready;
    assign err_len      = r_err_len;
    assign m_cnn_tvalid = r_m_valid;
    assign m_cnn_tdata  = {{(AXIS_W - PIX_W){1'b0}}, r_m_data};
    assign cnn_ap_start = r_ap_start;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_cnn_input_streamer.sv
// Randomised bench for cnn_input_streamer: a queue of expected beats per sent frame,
// a small CNN responder for ap_start/ap_ready/ap_done, and checks on outputs and counters.
module tb_cnn_input_streamer;

    localparam int F = 48 * 48;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [7:0]  s_pix_tdata;
    logic        s_pix_tvalid;
    logic        s_pix_tlast;
    logic        s_pix_tready;
    logic [31:0] m_cnn_tdata;
    logic        m_cnn_tvalid;
    logic        m_cnn_tready;
    logic        cnn_ap_start;
    logic        cnn_ap_ready;
    logic        cnn_ap_done;
    logic [15:0] frame_cnt;
    logic        err_len;

    always #5 ap_clk = ~ap_clk;

    cnn_input_streamer dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .s_pix_tdata  (s_pix_tdata),
        .s_pix_tvalid (s_pix_tvalid),
        .s_pix_tlast  (s_pix_tlast),
        .s_pix_tready (s_pix_tready),
        .m_cnn_tdata  (m_cnn_tdata),
        .m_cnn_tvalid (m_cnn_tvalid),
        .m_cnn_tready (m_cnn_tready),
        .cnn_ap_start (cnn_ap_start),
        .cnn_ap_ready (cnn_ap_ready),
        .cnn_ap_done  (cnn_ap_done),
        .frame_cnt    (frame_cnt),
        .err_len      (err_len)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    int exp_good    = 0;
    int exp_err     = 0;
    int err_seen    = 0;
    int starts      = 0;
    int dones       = 0;
    int beats_frame = 0;
    int beats_total = 0;
    int done_cd     = 0;
    int done_delay  = 3;
    bit rand_ready  = 1'b0;
    bit prev_stall  = 1'b0;
    bit start_wait  = 1'b0;
    bit stall_seen  = 1'b0;
    logic [31:0] prev_data;

    // CNN-side responder and output scoreboard, all decisions at the falling edge
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            m_cnn_tready = 1'b0;
            cnn_ap_ready = 1'b0;
            cnn_ap_done  = 1'b0;
            starts       = 0;
            dones        = 0;
            beats_frame  = 0;
            done_cd      = 0;
            prev_stall   = 1'b0;
            start_wait   = 1'b0;
        end else begin
            if (err_len) err_seen++;
            if (prev_stall) begin
                check("tvalid_hold", 64'(m_cnn_tvalid), 64'd1);
                check("tdata_hold", 64'(m_cnn_tdata), 64'(prev_data));
            end
            if (start_wait) check("ap_start_hold", 64'(cnn_ap_start), 64'd1);
            cnn_ap_ready = 1'b0;
            if (cnn_ap_start && $urandom_range(0, 3) == 0) begin
                cnn_ap_ready = 1'b1;
                starts++;
            end
            start_wait = cnn_ap_start && !cnn_ap_ready;

            cnn_ap_done = 1'b0;
            if (done_cd > 0) begin
                if (done_cd > 1 || starts > dones) begin
                    done_cd--;
                    if (done_cd == 0) begin
                        cnn_ap_done = 1'b1;
                        dones++;
                    end
                end
            end

            m_cnn_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_cnn_tvalid && m_cnn_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("beat", 64'(m_cnn_tdata), {56'h0, e});
                end
                beats_frame++;
                beats_total++;
                if (beats_frame == F) begin
                    beats_frame = 0;
                    done_cd     = (done_delay < 1) ? 1 : done_delay;
                end
            end
            prev_stall = m_cnn_tvalid && !m_cnn_tready;
            prev_data  = m_cnn_tdata;
        end
    end

    // mode 0: i%256, 1: constant cval, 2: random
    task automatic send_frame(input int len, input int mode, input logic [7:0] cval, input bit gaps);
        logic [7:0] px[];
        int to;
        px = new[len];
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       px[i] = 8'(i);
                1:       px[i] = cval;
                default: px[i] = 8'($urandom_range(0, 255));
            endcase
        end
        if (len >= F) begin
            for (int i = 0; i < F; i++) exp_q.push_back(px[i]);
            exp_good++;
        end
        if (len != F) exp_err++;
        stall_seen = 1'b0;
        for (int i = 0; i < len; i++) begin
            s_pix_tvalid = 1'b1;
            s_pix_tdata  = px[i];
            s_pix_tlast  = (i == len - 1);
            to = 0;
            while (!s_pix_tready && to < 20000) begin
                stall_seen = 1'b1;
                @(negedge ap_clk);
                to++;
            end
            if (to >= 20000) begin
                check("tready_timeout", 64'(s_pix_tready), 64'd1);
                s_pix_tvalid = 1'b0;
                s_pix_tlast  = 1'b0;
                return;
            end
            @(negedge ap_clk);
            if (gaps && $urandom_range(0, 7) == 0) begin
                s_pix_tvalid = 1'b0;
                @(negedge ap_clk);
            end
        end
        s_pix_tvalid = 1'b0;
        s_pix_tlast  = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int to = 0;
        while ((dones != exp_good || exp_q.size() != 0) && to < 30000) begin
            @(negedge ap_clk);
            to++;
        end
        check({tag, "_drain_timeout"}, 64'(to < 30000), 64'd1);
        repeat (4) @(negedge ap_clk);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_good)));
        check({tag, "_starts"}, 64'(starts), 64'(exp_good));
        check({tag, "_err_len"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_idle_tvalid"}, 64'(m_cnn_tvalid), 64'd0);
        check({tag, "_idle_start"}, 64'(cnn_ap_start), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_tready"}, 64'(s_pix_tready), 64'd0);
        check({tag, "_tvalid"}, 64'(m_cnn_tvalid), 64'd0);
        check({tag, "_tdata"}, 64'(m_cnn_tdata), 64'd0);
        check({tag, "_ap_start"}, 64'(cnn_ap_start), 64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_err_len"}, 64'(err_len), 64'd0);
    endtask

    initial begin
        int bt0;
        int to;
        ap_rst       = 1'b1;
        s_pix_tdata  = '0;
        s_pix_tvalid = 1'b0;
        s_pix_tlast  = 1'b0;
        m_cnn_tready = 1'b0;
        cnn_ap_ready = 1'b0;
        cnn_ap_done  = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check_zero("reset");
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // 1: ramp frame, free-flowing output
        send_frame(F, 0, 8'h00, 1'b0);
        wait_quiet("t1");

        // 2: three constant frames with slow ap_done; third must wait for a free bank
        done_delay = 500;
        send_frame(F, 1, 8'h11, 1'b0);
        send_frame(F, 1, 8'h22, 1'b0);
        send_frame(F, 1, 8'h33, 1'b0);
        check("t2_third_frame_stalled", 64'(stall_seen), 64'd1);
        wait_quiet("t2");
        done_delay = 3;

        // 3: random backpressure on the CNN side
        rand_ready = 1'b1;
        bt0 = beats_total;
        send_frame(F, 2, 8'h00, 1'b1);
        wait_quiet("t3");
        check("t3_beat_count", 64'(beats_total - bt0), 64'(F));
        rand_ready = 1'b0;

        // 4: short frame is discarded, next frame streams
        send_frame(1000, 2, 8'h00, 1'b1);
        repeat (100) @(negedge ap_clk);
        check("t4_no_start", 64'(cnn_ap_start), 64'd0);
        check("t4_starts", 64'(starts), 64'(exp_good));
        check("t4_err_len", 64'(err_seen), 64'(exp_err));
        send_frame(F, 2, 8'h00, 1'b1);
        wait_quiet("t4");

        // 5: long frame truncated, following frame stays aligned
        send_frame(2400, 2, 8'h00, 1'b0);
        send_frame(F, 2, 8'h00, 1'b0);
        wait_quiet("t5");

        // 6: reset in the middle of streaming
        send_frame(F, 2, 8'h00, 1'b0);
        to = 0;
        while (beats_frame < 700 && to < 20000) begin
            @(negedge ap_clk);
            to++;
        end
        check("t6_reach_beat700", 64'(to < 20000), 64'd1);
        @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        check_zero("t6_rst");
        ap_rst = 1'b0;
        exp_q.delete();
        exp_good = 0;
        repeat (5) @(negedge ap_clk);
        check("t6_bank_free", 64'(s_pix_tready), 64'd1);
        check("t6_no_start", 64'(cnn_ap_start), 64'd0);
        check("t6_frame_cnt0", 64'(frame_cnt), 64'd0);
        send_frame(F, 2, 8'h00, 1'b1);
        wait_quiet("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
